pc_uart_rx: RTL

- UART receive front end for the pipecleaner user project. It turns the serial line on a dedicated input pin into bytes for the core logic that drives uo_out.
- Format is 8 data bits, LSB first, with optional even parity and one stop bit.
- Recovers the bit stream with a fixed clocks-per-bit divider and mid-bit sampling.
- Delivers each byte through a one-entry valid/ready holding register and reports framing, parity and overrun errors as sticky flags.

---
 rtl/pc_uart_rx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pc_uart_rx.sv
// UART receiver: 8 data bits, LSB first, optional even parity, one stop bit.
// A fixed clocks-per-bit down-counter samples each bit in its centre. Each
// received byte lands in a one-entry valid/ready holding register. Framing,
// parity and overrun errors are kept as sticky flags.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge
// START     | half a bit into the start bit; confirm it is still low
// DATA      | sample 8 data bits, one per bit time
// PARITY    | sample the even-parity bit (only when PARITY_EN)
// STOP      | sample the stop bit; deliver the byte or flag an error
// WAIT_IDLE | break or framing error; hold until the line returns high
module pc_uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_drop;
    logic            r_done;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;
    logic            r_perr;
    logic            r_ovr;

    logic w_rxs;
    logic w_tc;
    logic w_load_half;
    logic w_load_bit;
    logic w_sample_data;
    logic w_sample_par;
    logic w_deliver;
    logic w_ferr_set;
    logic w_perr_set;
    logic w_busy;

    assign w_rxs = r_sync[1];
    assign w_tc  = (r_cnt == '0);

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rx_in};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; dropping ena abandons any frame in progress.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!w_rxs) w_next = S_START;
            S_START:     if (w_tc) w_next = w_rxs ? S_IDLE : S_DATA;
            S_DATA:      if (w_tc && (r_idx == 3'd7))
                             w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (w_tc) w_next = S_STOP;
            S_STOP:      if (w_tc) w_next = w_rxs ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_rxs) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (!ena) w_next = S_IDLE;
    end

    // FSM output decode: counter loads, sample strobes and error events.
    always_comb begin
        w_load_half   = 1'b0;
        w_load_bit    = 1'b0;
        w_sample_data = 1'b0;
        w_sample_par  = 1'b0;
        w_deliver     = 1'b0;
        w_ferr_set    = 1'b0;
        w_perr_set    = 1'b0;
        w_busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   w_load_half = !w_rxs;
            S_START:  w_load_bit  = w_tc && !w_rxs;
            S_DATA: begin
                w_sample_data = w_tc;
                w_load_bit    = w_tc;
            end
            S_PARITY: begin
                w_sample_par = w_tc;
                w_load_bit   = w_tc;
            end
            S_STOP: begin
                w_deliver  = w_tc && w_rxs && !r_drop;
                w_perr_set = w_tc && w_rxs && r_drop;
                w_ferr_set = w_tc && !w_rxs;
            end
            default: ;
        endcase
    end

    // Bit timer, bit index, shift register and parity drop marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_drop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_deliver && ena;
            if (!ena) begin
                r_cnt <= '0;
                r_idx <= 3'd0;
            end else begin
                if (w_load_half)     r_cnt <= HALF_LOAD;
                else if (w_load_bit) r_cnt <= FULL_LOAD;
                else if (!w_tc)      r_cnt <= r_cnt - CW'(1);

                if (w_load_half) begin
                    r_idx  <= 3'd0;
                    r_drop <= 1'b0;
                end
                if (w_sample_data) begin
                    r_shift[r_idx] <= w_rxs;
                    r_idx          <= r_idx + 3'd1;
                end
                if (w_sample_par && (w_rxs != ^r_shift)) r_drop <= 1'b1;
            end
        end
    end

    // Holding register with valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else if (r_done && (!r_valid || rx_ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
        end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_ferr_set && ena)                  r_ferr <= 1'b1;
            else if (err_clr)                       r_ferr <= 1'b0;
            if (w_perr_set && ena)                  r_perr <= 1'b1;
            else if (err_clr)                       r_perr <= 1'b0;
            if (r_done && r_valid && !rx_ready)     r_ovr  <= 1'b1;
            else if (err_clr)                       r_ovr  <= 1'b0;
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;
    assign busy       = w_busy;

endmodule
